// File: rtl/gcd_top.sv
// 4-bit greatest-common-divisor engine using repeated subtraction.
// Operands are captured on START, and the result is held on GCD_OUT while DONE is high.
module gcd_top (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] X,
   input  logic [3:0] Y,
   input  logic       START,
   output logic [3:0] GCD_OUT,
   output logic       DONE
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      DONE_S = 2'd2
   } state_t;

   state_t     state_r;
   logic [3:0] a_r;
   logic [3:0] b_r;
   logic       a_gt_b_s;
   logic       a_eq_b_s;
   logic [3:0] diff_s;

   // Comparator and subtractor: always larger minus smaller, so no underflow
   always_comb begin
      a_gt_b_s = (a_r > b_r);
      a_eq_b_s = (a_r == b_r);
      diff_s   = 4'd0;
      if (a_gt_b_s) begin
         diff_s = a_r - b_r;
      end else begin
         diff_s = b_r - a_r;
      end
   end

   // Controller and datapath registers; DONE is set on the same edge that enters DONE_S
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r <= IDLE;
         a_r     <= 4'd0;
         b_r     <= 4'd0;
         GCD_OUT <= 4'd0;
         DONE    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  a_r     <= X;
                  b_r     <= Y;
                  state_r <= CALC;
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (b_r == 4'd0) begin
                  GCD_OUT <= a_r;
                  DONE    <= 1'b1;
                  state_r <= DONE_S;
               end else if (a_r == 4'd0) begin
                  GCD_OUT <= b_r;
                  DONE    <= 1'b1;
                  state_r <= DONE_S;
               end else if (a_eq_b_s) begin
                  GCD_OUT <= a_r;
                  DONE    <= 1'b1;
                  state_r <= DONE_S;
               end else if (a_gt_b_s) begin
                  a_r     <= diff_s;
                  state_r <= CALC;
               end else begin
                  b_r     <= diff_s;
                  state_r <= CALC;
               end
            end
            DONE_S: begin
               // A held START must not retrigger; wait for it to drop
               if (!START) begin
                  DONE    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  DONE    <= 1'b1;
                  state_r <= DONE_S;
               end
            end
            default: begin
               DONE    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_top.sv
// Self-checking bench for gcd_top: directed corner cases plus random operands
// checked against an Euclid-based reference for both result and latency.
module tb_gcd_top;

   logic       CLK;
   logic       RESET;
   logic [3:0] X;
   logic [3:0] Y;
   logic       START;
   logic [3:0] GCD_OUT;
   logic       DONE;

   int tests_run;
   int tests_failed;

   gcd_top dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .X       (X),
      .Y       (Y),
      .START   (START),
      .GCD_OUT (GCD_OUT),
      .DONE    (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_gcd(input int x, input int y);
      int a, b, t;
      a = x;
      b = y;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Subtraction count equals the sum of Euclid quotients, minus one on the final exact step
   function automatic int ref_steps(input int x, input int y);
      int a, b, q, r, s;
      if (x == 0 || y == 0) return 0;
      a = x;
      b = y;
      s = 0;
      forever begin
         q = a / b;
         r = a % b;
         if (r == 0) begin
            s = s + q - 1;
            break;
         end
         s = s + q;
         a = b;
         b = r;
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_gcd(input int x, input int y, input bit pulse);
      int exp_g, exp_n, n;
      exp_g = ref_gcd(x, y);
      exp_n = ref_steps(x, y) + 2;
      X = 4'(x);
      Y = 4'(y);
      START = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) begin
            X = 4'($urandom);
            Y = 4'($urandom);
            if (pulse) START = 1'b0;
         end
      end while (!DONE && n < 40);
      check_eq($sformatf("latency(%0d,%0d)", x, y), n, exp_n);
      check_eq($sformatf("result(%0d,%0d)", x, y), int'(GCD_OUT), exp_g);
      if (!pulse) begin
         repeat (2) begin
            X = 4'($urandom);
            Y = 4'($urandom);
            tick();
            check_eq("done_held", int'(DONE), 1);
            check_eq("out_held", int'(GCD_OUT), exp_g);
         end
      end
      START = 1'b0;
      tick();
      check_eq("done_fall", int'(DONE), 0);
      check_eq("out_after_fall", int'(GCD_OUT), exp_g);
   endtask

   initial begin
      int a, b;
      tests_run    = 0;
      tests_failed = 0;
      X     = 4'd0;
      Y     = 4'd0;
      START = 1'b0;
      RESET = 1'b0;
      repeat (2) tick();
      check_eq("reset_done", int'(DONE), 0);
      check_eq("reset_out", int'(GCD_OUT), 0);
      RESET = 1'b1;
      X = 4'd5;
      Y = 4'd3;
      repeat (3) tick();
      check_eq("idle_done", int'(DONE), 0);
      check_eq("idle_out", int'(GCD_OUT), 0);

      run_gcd(4, 6, 1'b0);
      run_gcd(15, 1, 1'b0);
      run_gcd(9, 9, 1'b0);
      run_gcd(0, 7, 1'b0);
      run_gcd(12, 0, 1'b0);
      run_gcd(0, 0, 1'b0);
      run_gcd(1, 15, 1'b1);

      // Abort a long computation with reset
      run_gcd(10, 15, 1'b0);
      X = 4'd15;
      Y = 4'd1;
      START = 1'b1;
      repeat (5) tick();
      check_eq("pre_abort_done", int'(DONE), 0);
      RESET = 1'b0;
      #1;
      check_eq("abort_done", int'(DONE), 0);
      check_eq("abort_out", int'(GCD_OUT), 0);
      START = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      check_eq("post_abort_idle", int'(DONE), 0);
      run_gcd(8, 12, 1'b0);

      // Idle with changing operands keeps the previous result
      repeat (4) begin
         X = 4'($urandom);
         Y = 4'($urandom);
         tick();
         check_eq("idle_hold", int'(GCD_OUT), 4);
         check_eq("idle_nodone", int'(DONE), 0);
      end
      run_gcd(10, 4, 1'b0);

      for (int i = 0; i < 40; i++) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         run_gcd(a, b, bit'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
